// File: rtl/cpu_debug_pkg.sv
// Shared types for the debug monitor RAM arbiter: FSM states, pending JTAG
// command kinds and the bit positions of the fields inside the JTAG jdo word.
package cpu_debug_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CPU_RD,
        ST_JTAG_RD
    } state_e;

    typedef enum logic [1:0] {
        PEND_NONE,
        PEND_LOAD_RD,
        PEND_WR,
        PEND_RD
    } pend_e;

    localparam int unsigned JDO_ADDR_LSB  = 17;
    localparam int unsigned JDO_RD_FLAG   = 34;
    localparam int unsigned JDO_WDATA_MSB = 34;
    localparam int unsigned JDO_WDATA_LSB = 3;

endpackage

// File: rtl/cpu_debug_ocimem_arbiter.sv
// Arbitrates the single-port debug monitor RAM between JTAG commands and the CPU
// Avalon slave. Optional CPU write-protect: define CPU_DEBUG_OCIMEM_WRPROT_EN.
module cpu_debug_ocimem_arbiter
    import cpu_debug_pkg::*;
#(
    parameter int unsigned ADDR_W       = 8,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              take_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic              take_no_action_ocimem_a,
    input  logic [37:0]       jdo,
    input  logic              debugack,
    input  logic [ADDR_W-1:0] av_address,
    input  logic              av_read,
    input  logic              av_write,
    input  logic [31:0]       av_writedata,
    input  logic [3:0]        av_byteenable,
    output logic              av_waitrequest,
    output logic [31:0]       av_readdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_wr,
    output logic              ram_rd,
    output logic [3:0]        ram_be,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata,
    output logic [31:0]       MonDReg,
    output logic              monitor_ready,
    output logic              monitor_error
);

    localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

    state_e            state_q, state_d;
    pend_e             pend_q, pend_d;
    logic [ADDR_W-1:0] jaddr_q, jaddr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       mon_q, mon_d;
    logic              err_q, err_d;
    logic [SW-1:0]     starve_q, starve_d;

    logic cpu_req, jtag_pend, jtag_done, busy, wr_allow;
    logic unused;

    assign cpu_req   = av_read | av_write;
    assign jtag_pend = (pend_q != PEND_NONE);
    assign unused    = ^{jdo[37:35], jdo[2:0], debugack};

`ifdef CPU_DEBUG_OCIMEM_WRPROT_EN
    assign wr_allow = debugack;
`else
    assign wr_allow = 1'b1;
`endif

    always_comb begin
        state_d        = state_q;
        pend_d         = pend_q;
        jaddr_d        = jaddr_q;
        wdata_d        = wdata_q;
        mon_d          = mon_q;
        err_d          = err_q;
        starve_d       = jtag_pend ? starve_q : '0;
        jtag_done      = 1'b0;
        av_waitrequest = 1'b1;
        ram_rd         = 1'b0;
        ram_wr         = 1'b0;
        ram_addr       = jaddr_q;
        ram_be         = 4'hF;
        ram_wdata      = wdata_q;

        unique case (state_q)
            ST_IDLE: begin
                if (jtag_pend && (!cpu_req || starve_q == SW'(STARVE_LIMIT))) begin
                    starve_d = '0;
                    pend_d   = PEND_NONE;
                    if (pend_q == PEND_WR) begin
                        ram_wr    = 1'b1;
                        jaddr_d   = jaddr_q + ADDR_W'(1);
                        jtag_done = 1'b1;
                    end else begin
                        ram_rd  = 1'b1;
                        state_d = ST_JTAG_RD;
                    end
                end else if (cpu_req) begin
                    ram_addr  = av_address;
                    ram_be    = av_byteenable;
                    ram_wdata = av_writedata;
                    if (jtag_pend && starve_q != SW'(STARVE_LIMIT))
                        starve_d = starve_q + SW'(1);
                    if (av_write) begin
                        ram_wr         = wr_allow;
                        av_waitrequest = 1'b0;
                    end else begin
                        ram_rd  = 1'b1;
                        state_d = ST_CPU_RD;
                    end
                end
            end
            ST_CPU_RD: begin
                av_waitrequest = 1'b0;
                state_d        = ST_IDLE;
            end
            ST_JTAG_RD: begin
                mon_d     = ram_rdata;
                jaddr_d   = jaddr_q + ADDR_W'(1);
                jtag_done = 1'b1;
                state_d   = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // A command finishing this cycle frees the slot, so a pulse on this edge is accepted.
        busy = (jtag_pend || state_q == ST_JTAG_RD) && !jtag_done;
        if (take_action_ocimem_a || take_action_ocimem_b || take_no_action_ocimem_a) begin
            if (busy) begin
                err_d = 1'b1;
            end else if (take_action_ocimem_a) begin
                err_d   = 1'b0;
                jaddr_d = jdo[JDO_ADDR_LSB +: ADDR_W];
                pend_d  = jdo[JDO_RD_FLAG] ? PEND_LOAD_RD : PEND_NONE;
            end else if (take_action_ocimem_b) begin
                pend_d  = PEND_WR;
                wdata_d = jdo[JDO_WDATA_MSB:JDO_WDATA_LSB];
            end else begin
                pend_d = PEND_RD;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            pend_q   <= PEND_NONE;
            jaddr_q  <= '0;
            wdata_q  <= '0;
            mon_q    <= '0;
            err_q    <= 1'b0;
            starve_q <= '0;
        end else begin
            state_q  <= state_d;
            pend_q   <= pend_d;
            jaddr_q  <= jaddr_d;
            wdata_q  <= wdata_d;
            mon_q    <= mon_d;
            err_q    <= err_d;
            starve_q <= starve_d;
        end
    end

    assign av_readdata   = ram_rdata;
    assign MonDReg       = mon_q;
    assign monitor_error = err_q;
    assign monitor_ready = (pend_q == PEND_NONE) && (state_q != ST_JTAG_RD);

endmodule

// File: tb/tb_cpu_debug_ocimem_arbiter.sv
// Self-checking bench for cpu_debug_ocimem_arbiter: directed table, starvation/error/reset
// sequences and a randomized serial phase against a word-level memory model.
module tb_cpu_debug_ocimem_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        take_action_ocimem_a, take_action_ocimem_b, take_no_action_ocimem_a;
    logic [37:0] jdo;
    logic        debugack;
    logic [7:0]  av_address;
    logic        av_read, av_write;
    logic [31:0] av_writedata;
    logic [3:0]  av_byteenable;
    logic        av_waitrequest;
    logic [31:0] av_readdata;
    logic [7:0]  ram_addr;
    logic        ram_wr, ram_rd;
    logic [3:0]  ram_be;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;
    logic [31:0] MonDReg;
    logic        monitor_ready, monitor_error;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    cpu_debug_ocimem_arbiter #(.ADDR_W(8), .STARVE_LIMIT(4)) dut (
        .clk(clk), .reset_n(reset_n),
        .take_action_ocimem_a(take_action_ocimem_a),
        .take_action_ocimem_b(take_action_ocimem_b),
        .take_no_action_ocimem_a(take_no_action_ocimem_a),
        .jdo(jdo), .debugack(debugack),
        .av_address(av_address), .av_read(av_read), .av_write(av_write),
        .av_writedata(av_writedata), .av_byteenable(av_byteenable),
        .av_waitrequest(av_waitrequest), .av_readdata(av_readdata),
        .ram_addr(ram_addr), .ram_wr(ram_wr), .ram_rd(ram_rd), .ram_be(ram_be),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
        .MonDReg(MonDReg), .monitor_ready(monitor_ready), .monitor_error(monitor_error)
    );

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = nw[8*i +: 8];
        return r;
    endfunction

    // Monitor RAM model; the bench preloads it through the poke port.
    logic [31:0] mem [256];
    logic        poke_en = 1'b0;
    logic [7:0]  poke_addr;
    logic [31:0] poke_val;
    always @(posedge clk) begin
        if (poke_en) mem[poke_addr] <= poke_val;
        else if (ram_wr) mem[ram_addr] <= merge(mem[ram_addr], ram_wdata, ram_be);
        if (ram_rd) ram_rdata <= mem[ram_addr];
    end

    // Counts RAM writes not belonging to a completing CPU write.
    int jtag_wr_cnt = 0;
    always @(negedge clk) begin
        #2;
        if (ram_wr && !(av_write && !av_waitrequest)) jtag_wr_cnt++;
        if (reset_n && ram_wr && ram_rd) begin
            failures++;
            $display("FAIL ram_strobes got wr=1 rd=1 exp never both");
        end
    end

    task automatic check32(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic poke(input logic [7:0] a, input logic [31:0] v);
        @(negedge clk);
        poke_en = 1'b1; poke_addr = a; poke_val = v;
        @(negedge clk);
        poke_en = 1'b0;
    endtask

    function automatic logic [37:0] jdo_a(input logic [7:0] a, input logic rd);
        logic [37:0] j;
        j = '0;
        j[24:17] = a;
        j[34] = rd;
        return j;
    endfunction

    function automatic logic [37:0] jdo_b(input logic [31:0] d);
        logic [37:0] j;
        j = '0;
        j[34:3] = d;
        return j;
    endfunction

    task automatic wait_ready(input string name);
        bit ok;
        ok = 1'b0;
        for (int c = 0; c < 40; c++) begin
            #1;
            if (monitor_ready) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        if (!ok) begin
            checks++; failures++;
            $display("FAIL %s_timeout got=not_ready exp=ready", name);
        end
    endtask

    // kind: 0 = ocimem_a, 1 = ocimem_b, 2 = no_action_ocimem_a
    task automatic jtag_op(input int kind, input logic [37:0] j);
        @(negedge clk);
        jdo = j;
        take_action_ocimem_a    = (kind == 0);
        take_action_ocimem_b    = (kind == 1);
        take_no_action_ocimem_a = (kind == 2);
        @(negedge clk);
        take_action_ocimem_a = 1'b0; take_action_ocimem_b = 1'b0; take_no_action_ocimem_a = 1'b0;
        wait_ready("jtag");
    endtask

    task automatic cpu_xfer(input logic wr, input logic [7:0] a, input logic [31:0] d,
                            input logic [3:0] be, output logic [31:0] rd, output int lat);
        bit ok;
        @(negedge clk);
        av_address = a; av_write = wr; av_read = ~wr; av_writedata = d; av_byteenable = be;
        lat = 0; rd = '0; ok = 1'b0;
        for (int c = 0; c < 40; c++) begin
            #1;
            lat++;
            if (!av_waitrequest) begin rd = av_readdata; ok = 1'b1; break; end
            @(negedge clk);
        end
        if (!ok) begin
            checks++; failures++;
            $display("FAIL cpu_timeout got=waitrequest_high exp=completion");
        end
        @(negedge clk);
        av_read = 1'b0; av_write = 1'b0;
    endtask

    typedef enum int {OP_LOAD, OP_LOAD_RD, OP_JWR, OP_JRD, OP_CWR, OP_CRD} op_e;
    typedef struct {
        op_e         op;
        logic [7:0]  addr;
        logic [31:0] data;
        logic [3:0]  be;
        logic [31:0] exp;
    } vec_t;

    logic [31:0] ref_mem [256];

    initial begin
        vec_t        tbl[$];
        logic [31:0] got, d;
        logic [7:0]  a, ref_jaddr;
        logic [3:0]  be;
        int          lat, grants, wr0, bad;
        bit          seen;

        reset_n = 1'b0;
        take_action_ocimem_a = 1'b0; take_action_ocimem_b = 1'b0; take_no_action_ocimem_a = 1'b0;
        jdo = '0; debugack = 1'b0;
        av_address = '0; av_read = 1'b0; av_write = 1'b0; av_writedata = '0; av_byteenable = 4'hF;
        repeat (3) @(negedge clk);
        #1;
        check32("rst_waitrequest", {31'd0, av_waitrequest}, 32'd1);
        check32("rst_ready", {31'd0, monitor_ready}, 32'd1);
        check32("rst_error", {31'd0, monitor_error}, 32'd0);
        check32("rst_mondreg", MonDReg, 32'd0);
        check32("rst_strobes", {30'd0, ram_rd, ram_wr}, 32'd0);
        reset_n = 1'b1;

        poke(8'h10, 32'hDEADBEEF);
        poke(8'h11, 32'h11111111);
        poke(8'h01, 32'h01010101);
        poke(8'hFE, 32'h0); poke(8'hFF, 32'h0); poke(8'h00, 32'h0);

        tbl.push_back('{OP_LOAD_RD, 8'h10, 32'h0,        4'hF, 32'hDEADBEEF});
        tbl.push_back('{OP_JRD,     8'h00, 32'h0,        4'hF, 32'h11111111});
        tbl.push_back('{OP_LOAD,    8'hFE, 32'h0,        4'hF, 32'h0});
        tbl.push_back('{OP_JWR,     8'h00, 32'hA,        4'hF, 32'h0});
        tbl.push_back('{OP_JWR,     8'h00, 32'hB,        4'hF, 32'h0});
        tbl.push_back('{OP_JWR,     8'h00, 32'hC,        4'hF, 32'h0});
        tbl.push_back('{OP_CRD,     8'hFE, 32'h0,        4'hF, 32'hA});
        tbl.push_back('{OP_CRD,     8'hFF, 32'h0,        4'hF, 32'hB});
        tbl.push_back('{OP_CRD,     8'h00, 32'h0,        4'hF, 32'hC});
        tbl.push_back('{OP_JRD,     8'h00, 32'h0,        4'hF, 32'h01010101});
        tbl.push_back('{OP_CWR,     8'h20, 32'h55AA55AA, 4'hF, 32'h0});
        tbl.push_back('{OP_LOAD_RD, 8'h20, 32'h0,        4'hF, 32'h55AA55AA});
        tbl.push_back('{OP_CWR,     8'h20, 32'hFFFFFFFF, 4'h5, 32'h0});
        tbl.push_back('{OP_CRD,     8'h20, 32'h0,        4'hF, 32'h55FF55FF});

        foreach (tbl[i]) begin
            got = '0;
            case (tbl[i].op)
                OP_LOAD:    jtag_op(0, jdo_a(tbl[i].addr, 1'b0));
                OP_LOAD_RD: begin jtag_op(0, jdo_a(tbl[i].addr, 1'b1)); got = MonDReg; end
                OP_JWR:     jtag_op(1, jdo_b(tbl[i].data));
                OP_JRD:     begin jtag_op(2, '0); got = MonDReg; end
                OP_CWR:     cpu_xfer(1'b1, tbl[i].addr, tbl[i].data, tbl[i].be, got, lat);
                OP_CRD:     cpu_xfer(1'b0, tbl[i].addr, '0, tbl[i].be, got, lat);
                default: ;
            endcase
            if (tbl[i].op inside {OP_LOAD_RD, OP_JRD, OP_CRD})
                check32($sformatf("tbl%0d_data", i), got, tbl[i].exp);
            check32($sformatf("tbl%0d_error", i), {31'd0, monitor_error}, 32'd0);
        end

        // Starvation bound: CPU writes every cycle while a JTAG read waits.
        poke(8'h30, 32'hCAFEF00D);
        jtag_op(0, jdo_a(8'h30, 1'b0));
        @(negedge clk);
        av_write = 1'b1; av_address = 8'h40; av_writedata = 32'h4040; av_byteenable = 4'hF;
        take_no_action_ocimem_a = 1'b1;
        @(negedge clk);
        take_no_action_ocimem_a = 1'b0;
        grants = 0; seen = 1'b0;
        for (int c = 0; c < 20; c++) begin
            #1;
            if (ram_rd) begin seen = 1'b1; break; end
            if (!av_waitrequest) grants++;
            @(negedge clk);
        end
        check32("starve_jtag_seen", {31'd0, seen}, 32'd1);
        check32("starve_grants", grants, 32'd4);
        check32("starve_cpu_stalled_grant", {31'd0, av_waitrequest}, 32'd1);
        @(negedge clk); #1;
        check32("starve_cpu_stalled_rd", {31'd0, av_waitrequest}, 32'd1);
        @(negedge clk); #1;
        check32("starve_cpu_resumes", {31'd0, av_waitrequest}, 32'd0);
        @(negedge clk);
        av_write = 1'b0;
        wait_ready("starve");
        check32("starve_mondreg", MonDReg, 32'hCAFEF00D);

        // Overrun: second ocimem_b while the first is pending.
        poke(8'h50, 32'h0); poke(8'h51, 32'h0);
        jtag_op(0, jdo_a(8'h50, 1'b0));
        wr0 = jtag_wr_cnt;
        @(negedge clk);
        av_write = 1'b1; av_address = 8'h41;
        take_action_ocimem_b = 1'b1; jdo = jdo_b(32'h11112222);
        @(negedge clk);
        take_action_ocimem_b = 1'b0;
        @(negedge clk);
        take_action_ocimem_b = 1'b1; jdo = jdo_b(32'h33334444);
        @(negedge clk);
        take_action_ocimem_b = 1'b0;
        #1;
        check32("ovr_error_set", {31'd0, monitor_error}, 32'd1);
        av_write = 1'b0;
        wait_ready("ovr");
        repeat (2) @(negedge clk);
        check32("ovr_one_write", jtag_wr_cnt - wr0, 32'd1);
        check32("ovr_mem50", mem[8'h50], 32'h11112222);
        check32("ovr_mem51", mem[8'h51], 32'h0);
        jtag_op(2, '0);
        check32("ovr_error_sticky", {31'd0, monitor_error}, 32'd1);
        jtag_op(0, jdo_a(8'h50, 1'b1));
        check32("ovr_error_clear", {31'd0, monitor_error}, 32'd0);
        check32("ovr_readback", MonDReg, 32'h11112222);

        // CPU latencies.
        poke(8'h05, 32'h1234);
        cpu_xfer(1'b0, 8'h05, '0, 4'hF, got, lat);
        check32("cpu_rd_data", got, 32'h1234);
        check32("cpu_rd_lat", lat, 32'd2);
        cpu_xfer(1'b1, 8'h06, 32'h6666, 4'hF, got, lat);
        check32("cpu_wr_lat", lat, 32'd1);
        cpu_xfer(1'b0, 8'h06, '0, 4'hF, got, lat);
        check32("cpu_wr_data", got, 32'h6666);

        // Randomized serial traffic against a word-level model.
        for (int i = 0; i < 256; i++) begin
            d = $urandom;
            poke(i[7:0], d);
            ref_mem[i] = d;
        end
        ref_jaddr = 8'h0;
        jtag_op(0, jdo_a(8'h0, 1'b0));
        for (int n = 0; n < 150; n++) begin
            a = 8'($urandom_range(0, 255));
            d = $urandom;
            be = 4'($urandom_range(0, 15));
            case ($urandom_range(0, 4))
                0: begin
                    cpu_xfer(1'b1, a, d, be, got, lat);
                    ref_mem[a] = merge(ref_mem[a], d, be);
                    check32("rnd_cwr_lat", lat, 32'd1);
                end
                1: begin
                    cpu_xfer(1'b0, a, '0, 4'hF, got, lat);
                    check32("rnd_crd_data", got, ref_mem[a]);
                    check32("rnd_crd_lat", lat, 32'd2);
                end
                2: begin
                    seen = 1'($urandom_range(0, 1));
                    jtag_op(0, jdo_a(a, seen));
                    ref_jaddr = a;
                    if (seen) begin
                        check32("rnd_load_rd", MonDReg, ref_mem[ref_jaddr]);
                        ref_jaddr = ref_jaddr + 8'd1;
                    end
                end
                3: begin
                    jtag_op(1, jdo_b(d));
                    ref_mem[ref_jaddr] = d;
                    ref_jaddr = ref_jaddr + 8'd1;
                end
                default: begin
                    jtag_op(2, '0);
                    check32("rnd_jrd", MonDReg, ref_mem[ref_jaddr]);
                    ref_jaddr = ref_jaddr + 8'd1;
                end
            endcase
        end
        repeat (2) @(negedge clk);
        bad = 0;
        for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) bad++;
        check32("rnd_mem_words_wrong", bad, 32'd0);
        check32("rnd_error", {31'd0, monitor_error}, 32'd0);

        // Write protect and debugack.
        poke(8'h60, 32'h1);
        debugack = 1'b0;
        cpu_xfer(1'b1, 8'h60, 32'h9999, 4'hF, got, lat);
        check32("wp_lat", lat, 32'd1);
        @(negedge clk);
`ifdef CPU_DEBUG_OCIMEM_WRPROT_EN
        check32("wp_blocked", mem[8'h60], 32'h1);
`else
        check32("wp_blocked", mem[8'h60], 32'h9999);
`endif
        debugack = 1'b1;
        cpu_xfer(1'b1, 8'h60, 32'h7777, 4'hF, got, lat);
        @(negedge clk);
        check32("wp_allowed", mem[8'h60], 32'h7777);
        debugack = 1'b0;

        // Reset during a CPU read.
        @(negedge clk);
        av_read = 1'b1; av_address = 8'h70;
        @(negedge clk);
        av_read = 1'b0;
        reset_n = 1'b0;
        #1;
        check32("rst_cpu_rd_wait", {31'd0, av_waitrequest}, 32'd1);
        check32("rst_cpu_rd_strobe", {31'd0, ram_rd}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // Reset during a JTAG read, then jaddr restarts at 0.
        poke(8'h00, 32'h0BADF00D);
        jtag_op(0, jdo_a(8'h00, 1'b1));
        check32("pre_rst_mondreg", MonDReg, 32'h0BADF00D);
        jtag_op(0, jdo_a(8'h33, 1'b0));
        @(negedge clk);
        take_no_action_ocimem_a = 1'b1;
        @(negedge clk);
        take_no_action_ocimem_a = 1'b0;
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check32("rst_jrd_mondreg", MonDReg, 32'h0);
        check32("rst_jrd_ready", {31'd0, monitor_ready}, 32'd1);
        @(negedge clk);
        reset_n = 1'b1;
        jtag_op(2, '0);
        check32("rst_jaddr_zero", MonDReg, 32'h0BADF00D);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1);
    end

endmodule
